vga_frame_reader: RTL and testbench
===================================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter CAM_SCREEN_X, default 320, SHALL set the stored frame width in pixels.
REQ-002 Parameter CAM_SCREEN_Y, default 240, SHALL set the stored frame height in pixels.
REQ-003 Parameter AW, default 17, SHALL set the buffer address width; AW >= clog2(CAM_SCREEN_X*CAM_SCREEN_Y).
REQ-004 Parameter DW, default 8, SHALL set the pixel width (RGB332 at 8).
REQ-005 Parameter FILL_COLOR, default 8'h00, SHALL set the DW-bit colour shown outside the image window.
REQ-006 clk  in  1  single clock for all logic (25 MHz VGA clock); the block has one clock.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 posX  in  10  VGA driver next-pixel column.
REQ-009 posY  in  9  VGA driver next-pixel row.
REQ-010 mode  in  2  scale select: 00 = 1x, 01 = 2x, 10 = 4x, 11 = 1x.
REQ-011 swap_req  in  1  level request to flip the read bank (double buffering).
REQ-012 swap_ack  out  1  one-cycle pulse when a bank flip is performed.
REQ-013 rd_bank  out  1  current read bank; it selects the buffer half.
REQ-014 addr_out  out  AW  read address to the dual-port buffer (synchronous read, 1-cycle latency).
REQ-015 mem_data  in  DW  buffer read data.
REQ-016 pixel_out  out  DW  pixel to the VGA driver pixelIn.

Function
REQ-017 Frame start SHALL be detected on the first cycle where posX==0 && posY==0 and the previous sampled (posX,posY) was not (0,0).
REQ-018 The active scale (shift s = 0, 1 or 2) SHALL be latched from mode only at frame start; mode changes mid-frame SHALL have no effect until the next frame start.
REQ-019 Scaled coordinates SHALL be sx = posX >> s and sy = posY >> s (nearest-neighbour replication).
REQ-020 in_win SHALL be (sx < CAM_SCREEN_X) && (sy < CAM_SCREEN_Y).
REQ-021 When in_win is true, addr_out SHALL be sy*CAM_SCREEN_X + sx, truncated to AW bits; this is computed without a generic multiplier, using a row-base register plus offset.
REQ-022 When in_win is false, addr_out SHALL hold its previous value, so no spurious address toggling occurs.
REQ-023 addr_out SHALL be registered and valid 1 cycle after posX/posY are sampled.
REQ-024 pixel_out SHALL be registered and SHALL equal mem_data if in_win (delayed to match), else FILL_COLOR.
REQ-025 Total latency from posX/posY to pixel_out SHALL be exactly 3 cycles.
REQ-026 Bank FSM states SHALL be IDLE and PENDING:
- IDLE -> PENDING when swap_req==1.
- PENDING -> IDLE at frame start: rd_bank toggles and swap_ack pulses for 1 cycle.
REQ-027 swap_req asserted on the same cycle as frame start SHALL flip the bank at that same frame start.
REQ-028 swap_req held high continuously SHALL cause at most one flip per frame.
REQ-029 swap_req deasserting while in PENDING SHALL NOT cancel the pending flip.

Reset
REQ-030 While rst is high, the following SHALL hold:
- addr_out = 0, pixel_out = FILL_COLOR, rd_bank = 0, swap_ack = 0.
- FSM in IDLE, s = 0, row-base register = 0, delay pipeline cleared to not-in-window.
REQ-031 Reset asserted mid-frame SHALL drop any pending swap; after release, the first observed (0,0) SHALL count as a frame start.

Structure
REQ-032 The mode encodings, FSM state encodings and the default CAM_SCREEN_X/Y SHALL live in a shared package used by this block and the top level.
REQ-033 One sub-module, scale_addr_gen, SHALL contain the scaling, in_win and row-base address logic; swap FSM and output pipeline stay in vga_frame_reader.

Verification
REQ-034 mode=00, posX=5, posY=2 -> addr_out=645 after 1 cycle; pixel_out equals mem_data returned for 645, 3 cycles after input.
REQ-035 mode=01 latched at frame start, posX=639, posY=479 -> sx=319, sy=239, addr_out=76799; posX=640 equivalent is not reached, and posX=10,posY=0 gives addr_out=5.
REQ-036 mode=00, posX=320, posY=0 -> pixel_out=FILL_COLOR after 3 cycles, and addr_out unchanged from its previous value.
REQ-037 mode changed 00->10 at posY=100 -> addresses keep 1x mapping until the next (0,0), then posX=8,posY=4 gives addr_out=322.
REQ-038 swap_req pulse at posY=200 -> rd_bank flips, with swap_ack=1 for exactly one cycle, at the next frame start; swap_req held high for 3 frames -> exactly 3 flips.
REQ-039 rst asserted while PENDING -> rd_bank=0, swap_ack=0, pixel_out=FILL_COLOR immediately, and no flip at the next frame start.

Source files
------------

// File: rtl/vga_frame_reader_pkg.sv
// Shared definitions for the VGA frame reader: default camera frame size,
// scale-mode and swap-FSM encodings, and the mode-to-shift decode.
package vga_frame_reader_pkg;

  localparam int DEF_CAM_SCREEN_X = 320;
  localparam int DEF_CAM_SCREEN_Y = 240;

  typedef enum logic [1:0] {
    MODE_1X     = 2'b00,
    MODE_2X     = 2'b01,
    MODE_4X     = 2'b10,
    MODE_1X_ALT = 2'b11
  } scale_mode_e;

  typedef enum logic {
    BANK_IDLE    = 1'b0,
    BANK_PENDING = 1'b1
  } bank_state_e;

  function automatic logic [1:0] mode_shift(input logic [1:0] mode);
    case (scale_mode_e'(mode))
      MODE_2X: return 2'd1;
      MODE_4X: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_frame_reader_scale_addr_gen.sv
// Nearest-neighbour scaling of the VGA position into camera-frame coordinates,
// window test and multiplier-free buffer address (row base plus column offset).
module scale_addr_gen
  import vga_frame_reader_pkg::*;
#(
  parameter int CAM_SCREEN_X = DEF_CAM_SCREEN_X,
  parameter int CAM_SCREEN_Y = DEF_CAM_SCREEN_Y,
  parameter int AW           = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    posX,
  input  logic [8:0]    posY,
  input  logic [1:0]    shift,
  output logic          in_win,
  output logic [AW-1:0] addr
);

  localparam logic [9:0]    X_LIM    = 10'(CAM_SCREEN_X);
  localparam logic [8:0]    Y_LIM    = 9'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] ROW_STEP = AW'(CAM_SCREEN_X);

  logic [9:0]    sx;
  logic [8:0]    sy;
  logic [8:0]    last_sy;
  logic [AW-1:0] row_base;
  logic [AW-1:0] base;

  // NOTE: every branch assigns base, so no latch is inferred.
  always_comb begin
    sx     = posX >> shift;
    sy     = posY >> shift;
    in_win = (sx < X_LIM) && (sy < Y_LIM);
    // The raster only ever stays on a row, steps to the next one, or restarts at 0.
    if (sy == '0)           base = '0;
    else if (sy == last_sy) base = row_base;
    else                    base = row_base + ROW_STEP;
    addr = base + AW'(sx);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sy  <= '0;
      row_base <= '0;
    end else begin
      last_sy  <= sy;
      row_base <= base;
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Reads a double-buffered camera frame for a VGA driver: frame-start detection,
// bank-swap FSM and the 3-cycle address/pixel pipeline around a sync-read buffer.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int CAM_SCREEN_X         = DEF_CAM_SCREEN_X,
  parameter int CAM_SCREEN_Y         = DEF_CAM_SCREEN_Y,
  parameter int AW                   = 17,
  parameter int DW                   = 8,
  parameter logic [DW-1:0] FILL_COLOR = DW'(8'h00)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    posX,
  input  logic [8:0]    posY,
  input  logic [1:0]    mode,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          rd_bank,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] pixel_out
);

  bank_state_e   state, state_next;
  logic [1:0]    shift_q;
  logic          prev_zero;
  logic          frame_start;
  logic          flip;
  logic          in_win;
  logic [AW-1:0] addr_calc;
  logic          win_d1, win_d2;

  // prev_zero resets low so the first (0,0) after reset is a frame start.
  assign frame_start = (posX == '0) && (posY == '0) && !prev_zero;

  scale_addr_gen #(
    .CAM_SCREEN_X (CAM_SCREEN_X),
    .CAM_SCREEN_Y (CAM_SCREEN_Y),
    .AW           (AW)
  ) u_scale_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .posX   (posX),
    .posY   (posY),
    .shift  (shift_q),
    .in_win (in_win),
    .addr   (addr_calc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_zero <= 1'b0;
      shift_q   <= 2'd0;
    end else begin
      prev_zero <= (posX == '0) && (posY == '0);
      if (frame_start) shift_q <= mode_shift(mode);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BANK_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BANK_IDLE:    if (swap_req && !frame_start) state_next = BANK_PENDING;
      BANK_PENDING: if (frame_start)              state_next = BANK_IDLE;
      default:      state_next = BANK_IDLE;
    endcase
  end

  // A request arriving on the frame-start cycle flips immediately.
  always_comb begin
    flip = frame_start && ((state == BANK_PENDING) || swap_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      swap_ack  <= 1'b0;
      addr_out  <= '0;
      win_d1    <= 1'b0;
      win_d2    <= 1'b0;
      pixel_out <= FILL_COLOR;
    end else begin
      rd_bank  <= rd_bank ^ flip;
      swap_ack <= flip;
      // Hold the address outside the window so the buffer sees no spurious reads.
      if (in_win) addr_out <= addr_calc;
      win_d1    <= in_win;
      win_d2    <= win_d1;
      pixel_out <= win_d2 ? mem_data : FILL_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: compressed randomized rasters checked
// against an arithmetic reference model, plus swap and mid-frame reset scenarios.
module tb_vga_frame_reader;

  localparam logic [7:0] FILL = 8'hE3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  posX = '0;
  logic [8:0]  posY = '0;
  logic [1:0]  mode = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack, rd_bank;
  logic [16:0] addr_out;
  logic [7:0]  mem_data = '0;
  logic [7:0]  pixel_out;

  vga_frame_reader #(
    .CAM_SCREEN_X (320),
    .CAM_SCREEN_Y (240),
    .AW           (17),
    .DW           (8),
    .FILL_COLOR   (FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .posX      (posX),
    .posY      (posY),
    .mode      (mode),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .rd_bank   (rd_bank),
    .addr_out  (addr_out),
    .mem_data  (mem_data),
    .pixel_out (pixel_out)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] mem_f(input int a);
    return 8'((a * 13) ^ (a >> 8));
  endfunction

  // Synchronous-read buffer with known contents.
  always @(posedge clk) mem_data <= mem_f(int'(addr_out));

  typedef struct { int due; int val; } exp_t;
  exp_t q_addr[$];
  exp_t q_pix[$];
  exp_t q_ctl[$];

  int cyc = 0;
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  int ack_seen = 0;

  // Reference model state
  bit m_prev_zero;
  int m_s, m_addr;
  bit m_pending, m_bank;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  task automatic reset_model();
    m_prev_zero = 0; m_s = 0; m_addr = 0; m_pending = 0; m_bank = 0;
    q_addr.delete(); q_pix.delete(); q_ctl.delete();
  endtask

  // Monitor: pops every expectation that falls due on this clock.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (!rst) begin
      if (swap_ack) ack_seen++;
      while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
        e = q_addr.pop_front();
        check("addr_out", int'(addr_out), e.val);
      end
      while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
        e = q_pix.pop_front();
        check("pixel_out", int'(pixel_out), e.val);
      end
      while (q_ctl.size() > 0 && q_ctl[0].due <= cyc) begin
        e = q_ctl.pop_front();
        check("rd_bank", int'(rd_bank), e.val & 1);
        check("swap_ack", int'(swap_ack), e.val >> 1);
      end
    end
  end

  task automatic drive_pixel(input int x, input int y, input int m, input bit req);
    bit fs, win, flip;
    int sx, sy, pix;
    @(negedge clk);
    rst = 1'b0;
    posX = 10'(x); posY = 9'(y); mode = 2'(m); swap_req = req;
    n_vec++;
    fs = (x == 0 && y == 0) && !m_prev_zero;
    m_prev_zero = (x == 0 && y == 0);
    if (fs) m_s = (m == 1) ? 1 : (m == 2) ? 2 : 0;
    sx = x >> m_s;
    sy = y >> m_s;
    win = (sx < 320) && (sy < 240);
    if (win) m_addr = sy * 320 + sx;
    pix = win ? int'(mem_f(m_addr)) : int'(FILL);
    flip = fs && (m_pending || req);
    if (flip) begin
      m_bank = !m_bank;
      m_pending = 0;
    end else if (req && !fs) begin
      m_pending = 1;
    end
    q_addr.push_back('{cyc + 1, m_addr});
    q_pix.push_back('{cyc + 3, pix});
    q_ctl.push_back('{cyc + 1, (int'(flip) << 1) | int'(m_bank)});
  endtask

  // kind: 0 no request, 1 one-cycle pulse at row 200, 2 held high, 3 sparse random
  task automatic run_frame(input int mode_a, input int mode_b, input int kind, input int ymax);
    for (int y = 0; y <= ymax; y++) begin
      int xs[$];
      if (y == 0) begin xs.push_back(0); xs.push_back(10); xs.push_back(320); end
      if (y == 2) xs.push_back(5);
      if (y == 4) xs.push_back(8);
      if (y == 479) xs.push_back(639);
      repeat ($urandom_range(1, 2)) xs.push_back(int'($urandom_range(1, 639)));
      xs.sort();
      foreach (xs[i]) begin
        bit req;
        case (kind)
          1:       req = (y == 200) && (i == 0);
          2:       req = 1'b1;
          3:       req = ($urandom_range(0, 299) == 0);
          default: req = 1'b0;
        endcase
        drive_pixel(xs[i], y, (y < 100) ? mode_a : mode_b, req);
      end
    end
  endtask

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset addr_out", int'(addr_out), 0);
    check("reset pixel_out", int'(pixel_out), int'(FILL));
    check("reset rd_bank", int'(rd_bank), 0);
    check("reset swap_ack", int'(swap_ack), 0);

    run_frame(0, 0, 0, 499);   // 1x: (5,2)->645, (320,0) outside window
    run_frame(1, 1, 0, 499);   // 2x: (639,479)->76799, (10,0)->5
    run_frame(0, 2, 0, 499);   // mode change mid-frame takes no effect
    run_frame(2, 2, 1, 499);   // 4x: (8,4)->322; swap pulse at row 200
    run_frame(0, 0, 0, 499);   // flip lands on this frame start

    ack_seen = 0;
    repeat (3) run_frame(0, 1, 2, 499);
    @(posedge clk); #2;
    check("held swap_req flips", ack_seen, 3);
    run_frame(0, 0, 0, 499);

    repeat (6) run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(479, 511)));

    run_frame(0, 0, 0, 499);
    if (m_bank == 0) run_frame(0, 0, 1, 499);
    run_frame(0, 0, 1, 210);   // stop mid-frame with a swap pending
    #7 rst = 1'b1;
    #1;
    check("midrst addr_out", int'(addr_out), 0);
    check("midrst pixel_out", int'(pixel_out), int'(FILL));
    check("midrst rd_bank", int'(rd_bank), 0);
    check("midrst swap_ack", int'(swap_ack), 0);
    reset_model();
    repeat (2) @(posedge clk);
    ack_seen = 0;
    run_frame(1, 1, 0, 499);
    @(posedge clk); #2;
    check("no flip after reset", ack_seen, 0);

    repeat (4) drive_pixel(1, 0, 0, 0);
    @(posedge clk); #2;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", q_addr.size() + q_pix.size() + q_ctl.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
